// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stall controller: stall-bit indices,
// divide FSM states and a helper that builds monotone stall masks.
package pipe_pkg;

  localparam int STALL_W       = 5;
  localparam int STALL_PC      = 0;
  localparam int STALL_IF2ID   = 1;
  localparam int STALL_ID2EXE  = 2;
  localparam int STALL_EXE2MEM = 3;
  localparam int STALL_MEM2WB  = 4;

  typedef enum logic {
    IDLE,
    DIV_BUSY
  } div_state_t;

  // Holding a stage means every stage upstream of it must hold too, so a
  // stall is expressed as "everything up to and including bit top".
  function automatic logic [STALL_W-1:0] stall_upto(input int top);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int k = 0; k < STALL_W; k++) begin
      if (k <= top) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit wrapping event counter with enable, cleared by synchronous reset.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: MEM wait > divide occupancy > load-use.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_reg1_read_i,
  input  logic [4:0]   id_reg1_addr_i,
  input  logic         id_reg2_read_i,
  input  logic [4:0]   id_reg2_addr_i,
  input  logic         exe_rmem_i,
  input  logic [4:0]   exe_wd_i,
  input  logic         exe_div_i,
  input  logic         mem_req_i,
  input  logic         mem_ack_i,
  output logic [STALL_W-1:0] stall_o,
  output logic         id_bubble_o,
  output logic         exe_bubble_o,
  output logic         mem_bubble_o,
  output logic         div_done_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_stall_cyc_o,
  output logic [31:0]  perf_div_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_CYCLES - 2);

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mem_wait, load_use, div_stall, div_last;

  assign mem_wait = mem_req_i & ~mem_ack_i;
  assign load_use = exe_rmem_i && (exe_wd_i != 5'd0) &&
                    ((id_reg1_read_i && (id_reg1_addr_i == exe_wd_i)) ||
                     (id_reg2_read_i && (id_reg2_addr_i == exe_wd_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // A MEM wait freezes the divide entirely, stretching its occupancy by one cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_stall  = 1'b0;
    div_last   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (exe_div_i && !mem_wait) begin
          div_stall  = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        if (!mem_wait) begin
          if (cnt_reg != '0) begin
            div_stall = 1'b1;
            cnt_next  = cnt_reg - 1'b1;
          end else begin
            div_last   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_o      = '0;
    id_bubble_o  = 1'b0;
    exe_bubble_o = 1'b0;
    mem_bubble_o = 1'b0;
    div_done_o   = 1'b0;
    if (!rst) begin
      div_done_o = div_last;
      if (mem_wait) begin
        stall_o      = stall_upto(STALL_EXE2MEM);
        mem_bubble_o = 1'b1;
      end else if (div_stall) begin
        stall_o      = stall_upto(STALL_ID2EXE);
        exe_bubble_o = 1'b1;
      end else if (load_use) begin
        stall_o     = stall_upto(STALL_IF2ID);
        id_bubble_o = 1'b1;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_o[STALL_PC]),
    .count (perf_stall_cyc_o)
  );

  pipe_perf_cnt u_div_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (div_done_o),
    .count (perf_div_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed cycle table, then random stimulus against an
// occupancy-based reference model. Perf checks compile in with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

  localparam int DIVC = 4;

  typedef struct {
    logic       rst;
    logic       r1;
    logic [4:0] a1;
    logic       r2;
    logic [4:0] a2;
    logic       rmem;
    logic [4:0] wd;
    logic       div;
    logic       req;
    logic       ack;
  } in_t;

  typedef struct {
    in_t        i;
    logic [8:0] exp; // {stall[4:0], id_bubble, exe_bubble, mem_bubble, div_done}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_reg1_read_i, id_reg2_read_i, exe_rmem_i, exe_div_i, mem_req_i, mem_ack_i;
  logic [4:0] id_reg1_addr_i, id_reg2_addr_i, exe_wd_i;
  logic [4:0] stall_o;
  logic       id_bubble_o, exe_bubble_o, mem_bubble_o, div_done_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_o, perf_div_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_reg1_read_i (id_reg1_read_i),
    .id_reg1_addr_i (id_reg1_addr_i),
    .id_reg2_read_i (id_reg2_read_i),
    .id_reg2_addr_i (id_reg2_addr_i),
    .exe_rmem_i     (exe_rmem_i),
    .exe_wd_i       (exe_wd_i),
    .exe_div_i      (exe_div_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .stall_o        (stall_o),
    .id_bubble_o    (id_bubble_o),
    .exe_bubble_o   (exe_bubble_o),
    .mem_bubble_o   (mem_bubble_o),
    .div_done_o     (div_done_o)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_div_cnt_o   (perf_div_cnt_o)
`endif
  );

  int checks = 0;
  int passed = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic r1, logic [4:0] a1, logic r2, logic [4:0] a2,
                              logic rmem, logic [4:0] wd, logic div, logic req, logic ack,
                              logic [4:0] st, logic idb, logic exb, logic mb, logic dd);
    vec_t v;
    v.i   = '{rst: rs, r1: r1, a1: a1, r2: r2, a2: a2, rmem: rmem, wd: wd,
              div: div, req: req, ack: ack};
    v.exp = {st, idb, exb, mb, dd};
    return v;
  endfunction

  task automatic drive(input in_t v);
    rst            = v.rst;
    id_reg1_read_i = v.r1;
    id_reg1_addr_i = v.a1;
    id_reg2_read_i = v.r2;
    id_reg2_addr_i = v.a2;
    exe_rmem_i     = v.rmem;
    exe_wd_i       = v.wd;
    exe_div_i      = v.div;
    mem_req_i      = v.req;
    mem_ack_i      = v.ack;
  endtask

  task automatic check(input string name, input int idx, input logic [8:0] exp);
    logic [8:0] got;
    got = {stall_o, id_bubble_o, exe_bubble_o, mem_bubble_o, div_done_o};
    checks++;
    if (got === exp) begin
      passed++;
      $display("%s %0d: rst=%b div=%b req=%b ack=%b -> stall=%b idb=%b exb=%b mb=%b done=%b ok",
               name, idx, rst, exe_div_i, mem_req_i, mem_ack_i, got[8:4], got[3], got[2], got[1], got[0]);
    end else begin
      $display("FAIL %s %0d: got stall=%b b/id,exe,mem=%b done=%b, required stall=%b b=%b done=%b",
               name, idx, got[8:4], got[3:1], got[0], exp[8:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passed++;
      $display("%s: %0d ok", name, got);
    end else begin
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  in_t  ri;
  int   rem, rem_now, exp_stall_cnt, exp_div_cnt;
  logic mw, lu;
  logic [8:0] e;

  initial begin
    drive('{rst: 1'b1, r1: 1'b0, a1: 5'd0, r2: 1'b0, a2: 5'd0, rmem: 1'b0, wd: 5'd0,
            div: 1'b0, req: 1'b0, ack: 1'b0});

    //        rst r1 a1    r2 a2    rmem wd    div req ack   stall     idb exb mb dd
    tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 1, 0,  5'b00000, 0, 0, 0, 0)); // reset forces 0
    tbl.push_back(mk(0, 0, 0,  1, 5,  1, 5,  0, 0, 0,  5'b00011, 1, 0, 0, 0)); // load-use on rt
    tbl.push_back(mk(0, 0, 0,  1, 0,  1, 0,  0, 0, 0,  5'b00000, 0, 0, 0, 0)); // r0 never hazards
    tbl.push_back(mk(0, 1, 7,  0, 0,  1, 7,  0, 0, 0,  5'b00011, 1, 0, 0, 0)); // load-use on rs
    tbl.push_back(mk(0, 0, 7,  0, 7,  1, 7,  0, 0, 0,  5'b00000, 0, 0, 0, 0)); // match but not read
    tbl.push_back(mk(0, 1, 7,  1, 7,  0, 7,  0, 0, 0,  5'b00000, 0, 0, 0, 0)); // not a load
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 1,  5'b00000, 0, 0, 0, 0)); // ack without req
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 1,  5'b00000, 0, 0, 0, 0)); // req acked
    tbl.push_back(mk(0, 0, 0,  1, 5,  1, 5,  1, 1, 0,  5'b01111, 0, 0, 1, 0)); // all three causes
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // divide c0
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // c1
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // c2
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00000, 0, 0, 0, 1)); // c3 done
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // back-to-back c0
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 1, 0,  5'b01111, 0, 0, 1, 0)); // mem wait
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 1, 0,  5'b01111, 0, 0, 1, 0)); // mem wait
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00000, 0, 0, 0, 1)); // done at c5
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // divide c0
    tbl.push_back(mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00000, 0, 0, 0, 0)); // reset aborts
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // restart c0
    tbl.push_back(mk(0, 0, 0,  1, 3,  1, 3,  1, 0, 0,  5'b00111, 0, 1, 0, 0)); // div beats load-use
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  1, 0, 0,  5'b00111, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3,  0, 0,  1, 3,  1, 0, 0,  5'b00011, 1, 0, 0, 1)); // done + load-use
    tbl.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  5'b00000, 0, 0, 0, 0)); // idle

    foreach (tbl[n]) begin
      @(negedge clk);
      drive(tbl[n].i);
      #1;
      check("vec", n, tbl[n].exp);
    end

`ifdef PIPE_CTRL_PERF_EN
    // Since the mid-table reset: three divide stall cycles plus one load-use, one divide done.
    @(negedge clk);
    check32("perf_stall_after_table", perf_stall_cyc_o, 32'd4);
    check32("perf_div_after_table", perf_div_cnt_o, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exe_div_i = 1'b1;
    for (int k = 0; k < 2 * DIVC; k++) @(negedge clk);
    exe_div_i = 1'b0;
    @(negedge clk);
    check32("perf_stall_two_divs", perf_stall_cyc_o, 32'd6);
    check32("perf_div_two_divs", perf_div_cnt_o, 32'd2);
`endif

    // Random phase: rem = EXE cycles still owed to the divide in flight.
    rem = 0;
    exp_stall_cnt = 0;
    exp_div_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      ri.rst  = (n == 0) || ($urandom_range(39) == 0);
      ri.r1   = 1'($urandom);
      ri.a1   = 5'($urandom_range(3));
      ri.r2   = 1'($urandom);
      ri.a2   = 5'($urandom_range(3));
      ri.rmem = 1'($urandom);
      ri.wd   = 5'($urandom_range(3));
      ri.div  = ($urandom_range(3) == 0);
      ri.req  = ($urandom_range(3) == 0);
      ri.ack  = 1'($urandom);

      e = '0;
      if (ri.rst) begin
        rem = 0;
        exp_stall_cnt = 0;
        exp_div_cnt = 0;
      end else begin
        mw = ri.req && !ri.ack;
        lu = ri.rmem && (ri.wd != 0) &&
             ((ri.r1 && ri.a1 == ri.wd) || (ri.r2 && ri.a2 == ri.wd));
        rem_now = (!mw && rem == 0 && ri.div) ? DIVC : rem;
        if (mw)               e = {5'b01111, 4'b0010};
        else if (rem_now > 1) e = {5'b00111, 4'b0100};
        else if (lu)          e = {5'b00011, 4'b1000};
        if (!mw && rem_now == 1) e[0] = 1'b1;
        if (!mw) rem = (rem_now > 0) ? rem_now - 1 : 0;
        exp_stall_cnt += int'(e[4]);
        exp_div_cnt += int'(e[0]);
      end

      @(negedge clk);
      drive(ri);
      #1;
      check("rnd", n, e);
    end

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    check32("perf_stall_random", perf_stall_cyc_o, 32'(exp_stall_cnt));
    check32("perf_div_random", perf_div_cnt_o, 32'(exp_div_cnt));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
